// File: rtl/core_pkg.sv
// Core-wide types shared by the fetch stage and its neighbours.
`include "inst_defs.sv"
package core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  // One buffered fetch result as handed to decode.
  typedef struct packed {
    logic [`REG_RANGE] instruction;
    logic [`REG_RANGE] pc;
  } fetch_entry_t;

  localparam logic [`REG_RANGE] NOP_INSTR   = 32'h0000_0013;
  localparam logic [`REG_RANGE] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/inst_defs.sv
// Shared register-width macros for the core.
`ifndef INST_DEFS_SV
`define INST_DEFS_SV
`define XLEN 32
`define REG_RANGE 31:0
`endif

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head is read straight from storage so
// the consumer sees registered data. DEPTH must be a power of two >= 2.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    FULL    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);
  localparam logic [AW:0]    CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // A pop frees the slot a same-cycle push may use when full.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates validity.
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= push_data;

  // Pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues word requests, buffers
// responses and hands {instruction, pc, pc_4} to decode.
// Optional feature: IFETCH_MISALIGN_CHECK_EN turns misaligned redirect
// targets into a sticky FAULT state; otherwise the low target bits are cleared.
`include "inst_defs.sv"
module inst_fetch
  import core_pkg::*;
#(
  parameter logic [`REG_RANGE] RESET_PC   = 32'h0000_0000,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [`REG_RANGE] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [`REG_RANGE] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [`REG_RANGE] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [`REG_RANGE] instruction,
  output logic [`REG_RANGE] pc,
  output logic [`REG_RANGE] pc_4,
  output logic              fetch_fault
);
  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_V = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]   ONE     = CW'(1);

  fetch_state_e      state, state_nxt;
  logic [`REG_RANGE] fetch_pc, target_pc, addr_head;
  logic [CW-1:0]     outstanding, drop_cnt, buf_count, addr_count;
  logic [CW:0]       occupancy;
  logic              running, redir, accept, pop, rsp_keep;
  logic [$bits(fetch_entry_t)-1:0] head_bits;
  fetch_entry_t      head, push_entry;

  assign running = (state == RUN);
  assign redir   = running && redirect_valid;
  assign pop     = if_valid && if_ready;
  assign accept  = imem_req_valid && imem_req_ready;

  // Budget counts requests in flight plus buffered words; a same-cycle pop
  // is credited so the stage sustains one instruction per cycle.
  assign occupancy = {1'b0, outstanding} + {1'b0, buf_count} - (CW+1)'(pop);

  // Stale responses (drop_cnt) and those in a redirect cycle never reach the buffer.
  assign rsp_keep = imem_rsp_valid && running && !redirect_valid &&
                    (drop_cnt == '0) && (addr_count != '0);

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |redirect_pc[1:0];
  assign target_pc  = redirect_pc;
`else
  assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;

  // Next state, request valid and fault flag.
  always_comb begin
    state_nxt      = state;
    imem_req_valid = running && !redirect_valid && (occupancy < DEPTH_V);
    fetch_fault    = 1'b0;
    case (state)
      IDLE: state_nxt = RUN;
`ifdef IFETCH_MISALIGN_CHECK_EN
      RUN:   if (redirect_valid && misaligned) state_nxt = FAULT;
      FAULT: fetch_fault = 1'b1;
`endif
      default: state_nxt = state;
    endcase
  end

  assign imem_addr = fetch_pc;

  // Fetch PC: redirect wins over sequential advance; wraps modulo 2^32.
  always_ff @(posedge clk or negedge reset)
    if (!reset)      fetch_pc <= RESET_PC;
    else if (redir)  fetch_pc <= target_pc;
    else if (accept) fetch_pc <= fetch_pc + INSTR_BYTES;

  // Requests in flight: every response retires one, kept or dropped.
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      outstanding <= '0;
    else if (accept && !imem_rsp_valid)
      outstanding <= outstanding + ONE;
    else if (!accept && imem_rsp_valid && (outstanding != '0))
      outstanding <= outstanding - ONE;

  // Responses still owed to the old path after a redirect are discarded.
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      drop_cnt <= '0;
    else if (redir)
      drop_cnt <= (imem_rsp_valid && (outstanding != '0)) ? outstanding - ONE
                                                           : outstanding;
    else if (imem_rsp_valid && (drop_cnt != '0))
      drop_cnt <= drop_cnt - ONE;

  // Addresses of live requests, matched in order to their responses.
  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_addr_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (redir),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .head      (addr_head),
    .count     (addr_count)
  );

  assign push_entry = '{instruction: imem_rsp_data, pc: addr_head};

  // Instruction buffer feeding decode.
  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redir),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop && !redir),
    .head      (head_bits),
    .count     (buf_count)
  );

  // Outputs read zero whenever nothing valid is presented.
  assign head        = fetch_entry_t'(head_bits);
  assign if_valid    = (buf_count != '0);
  assign instruction = if_valid ? head.instruction : '0;
  assign pc          = if_valid ? head.pc : '0;
  assign pc_4        = if_valid ? head.pc + INSTR_BYTES : '0;

endmodule
